// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU and LSB results in private FIFOs and
// broadcasts one result per cycle, alternating between sources on contention.
module cdb_arbiter #(
   parameter int ROB_IDX_W  = 4,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clr_in,

   input  logic                 alu_ready,
   input  logic [ROB_IDX_W-1:0] alu_rob_index,
   input  logic [DATA_W-1:0]    alu_result,
   output logic                 alu_full,

   input  logic                 lsb_ready,
   input  logic [ROB_IDX_W-1:0] lsb_rob_index,
   input  logic [DATA_W-1:0]    lsb_result,
   output logic                 lsb_full,

   output logic                 cdb_valid,
   output logic [ROB_IDX_W-1:0] cdb_rob_index,
   output logic [DATA_W-1:0]    cdb_result,
   output logic                 cdb_src
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_LSB = 1'b1;

   // Handshake: src_ready is a single-cycle valid with no ready/ack; src_full
   // is the back-pressure and a source must not offer a result while it is
   // high. An entry offered while full is dropped without any state change.

   logic [ROB_IDX_W-1:0] alu_tag_q [FIFO_DEPTH];
   logic [ROB_IDX_W-1:0] alu_tag_d [FIFO_DEPTH];
   logic [DATA_W-1:0]    alu_data_q [FIFO_DEPTH];
   logic [DATA_W-1:0]    alu_data_d [FIFO_DEPTH];
   logic [PTR_W-1:0]     alu_wr_ptr_q, alu_wr_ptr_d;
   logic [PTR_W-1:0]     alu_rd_ptr_q, alu_rd_ptr_d;
   logic [CNT_W-1:0]     alu_cnt_q, alu_cnt_d;

   logic [ROB_IDX_W-1:0] lsb_tag_q [FIFO_DEPTH];
   logic [ROB_IDX_W-1:0] lsb_tag_d [FIFO_DEPTH];
   logic [DATA_W-1:0]    lsb_data_q [FIFO_DEPTH];
   logic [DATA_W-1:0]    lsb_data_d [FIFO_DEPTH];
   logic [PTR_W-1:0]     lsb_wr_ptr_q, lsb_wr_ptr_d;
   logic [PTR_W-1:0]     lsb_rd_ptr_q, lsb_rd_ptr_d;
   logic [CNT_W-1:0]     lsb_cnt_q, lsb_cnt_d;

   logic                 last_grant_q, last_grant_d;
   logic                 cdb_valid_q, cdb_valid_d;
   logic [ROB_IDX_W-1:0] cdb_tag_q, cdb_tag_d;
   logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;
   logic                 cdb_src_q, cdb_src_d;

   logic alu_nonempty, lsb_nonempty;
   logic grant_alu, grant_lsb;
   logic alu_push, alu_pop, lsb_push, lsb_pop;

   assign alu_full = (alu_cnt_q == CNT_FULL);
   assign lsb_full = (lsb_cnt_q == CNT_FULL);

   assign cdb_valid     = cdb_valid_q;
   assign cdb_rob_index = cdb_tag_q;
   assign cdb_result    = cdb_data_q;
   assign cdb_src       = cdb_src_q;

   // On a tie the source that did not win last time gets the bus.
   always_comb begin
      alu_nonempty = (alu_cnt_q != '0);
      lsb_nonempty = (lsb_cnt_q != '0);
      grant_alu    = alu_nonempty && (!lsb_nonempty || (last_grant_q == SRC_LSB));
      grant_lsb    = lsb_nonempty && (!alu_nonempty || (last_grant_q == SRC_ALU));
   end

   always_comb begin
      alu_push = rdy_in && !clr_in && alu_ready && !alu_full;
      lsb_push = rdy_in && !clr_in && lsb_ready && !lsb_full;
      alu_pop  = rdy_in && !clr_in && grant_alu;
      lsb_pop  = rdy_in && !clr_in && grant_lsb;
   end

   always_comb begin
      alu_tag_d    = alu_tag_q;
      alu_data_d   = alu_data_q;
      alu_wr_ptr_d = alu_wr_ptr_q;
      alu_rd_ptr_d = alu_rd_ptr_q;
      alu_cnt_d    = alu_cnt_q;
      lsb_tag_d    = lsb_tag_q;
      lsb_data_d   = lsb_data_q;
      lsb_wr_ptr_d = lsb_wr_ptr_q;
      lsb_rd_ptr_d = lsb_rd_ptr_q;
      lsb_cnt_d    = lsb_cnt_q;
      last_grant_d = last_grant_q;
      cdb_valid_d  = cdb_valid_q;
      cdb_tag_d    = cdb_tag_q;
      cdb_data_d   = cdb_data_q;
      cdb_src_d    = cdb_src_q;

      if (clr_in) begin
         // Flush empties both queues but keeps the fairness history.
         alu_wr_ptr_d = '0;
         alu_rd_ptr_d = '0;
         alu_cnt_d    = '0;
         lsb_wr_ptr_d = '0;
         lsb_rd_ptr_d = '0;
         lsb_cnt_d    = '0;
         cdb_valid_d  = 1'b0;
      end else if (rdy_in) begin
         if (alu_push) begin
            alu_tag_d[alu_wr_ptr_q]  = alu_rob_index;
            alu_data_d[alu_wr_ptr_q] = alu_result;
            alu_wr_ptr_d             = alu_wr_ptr_q + PTR_ONE;
         end
         if (alu_pop) begin
            alu_rd_ptr_d = alu_rd_ptr_q + PTR_ONE;
         end
         if (alu_push && !alu_pop) begin
            alu_cnt_d = alu_cnt_q + CNT_ONE;
         end else if (!alu_push && alu_pop) begin
            alu_cnt_d = alu_cnt_q - CNT_ONE;
         end

         if (lsb_push) begin
            lsb_tag_d[lsb_wr_ptr_q]  = lsb_rob_index;
            lsb_data_d[lsb_wr_ptr_q] = lsb_result;
            lsb_wr_ptr_d             = lsb_wr_ptr_q + PTR_ONE;
         end
         if (lsb_pop) begin
            lsb_rd_ptr_d = lsb_rd_ptr_q + PTR_ONE;
         end
         if (lsb_push && !lsb_pop) begin
            lsb_cnt_d = lsb_cnt_q + CNT_ONE;
         end else if (!lsb_push && lsb_pop) begin
            lsb_cnt_d = lsb_cnt_q - CNT_ONE;
         end

         if (alu_pop) begin
            cdb_valid_d  = 1'b1;
            cdb_tag_d    = alu_tag_q[alu_rd_ptr_q];
            cdb_data_d   = alu_data_q[alu_rd_ptr_q];
            cdb_src_d    = SRC_ALU;
            last_grant_d = SRC_ALU;
         end else if (lsb_pop) begin
            cdb_valid_d  = 1'b1;
            cdb_tag_d    = lsb_tag_q[lsb_rd_ptr_q];
            cdb_data_d   = lsb_data_q[lsb_rd_ptr_q];
            cdb_src_d    = SRC_LSB;
            last_grant_d = SRC_LSB;
         end else begin
            cdb_valid_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            alu_tag_q[i]  <= '0;
            alu_data_q[i] <= '0;
            lsb_tag_q[i]  <= '0;
            lsb_data_q[i] <= '0;
         end
         alu_wr_ptr_q <= '0;
         alu_rd_ptr_q <= '0;
         alu_cnt_q    <= '0;
         lsb_wr_ptr_q <= '0;
         lsb_rd_ptr_q <= '0;
         lsb_cnt_q    <= '0;
         last_grant_q <= SRC_LSB;
         cdb_valid_q  <= 1'b0;
         cdb_tag_q    <= '0;
         cdb_data_q   <= '0;
         cdb_src_q    <= SRC_ALU;
      end else begin
         alu_tag_q    <= alu_tag_d;
         alu_data_q   <= alu_data_d;
         alu_wr_ptr_q <= alu_wr_ptr_d;
         alu_rd_ptr_q <= alu_rd_ptr_d;
         alu_cnt_q    <= alu_cnt_d;
         lsb_tag_q    <= lsb_tag_d;
         lsb_data_q   <= lsb_data_d;
         lsb_wr_ptr_q <= lsb_wr_ptr_d;
         lsb_rd_ptr_q <= lsb_rd_ptr_d;
         lsb_cnt_q    <= lsb_cnt_d;
         last_grant_q <= last_grant_d;
         cdb_valid_q  <= cdb_valid_d;
         cdb_tag_q    <= cdb_tag_d;
         cdb_data_q   <= cdb_data_d;
         cdb_src_q    <= cdb_src_d;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-computed broadcast sequences for
// single source, contention, fill/full, flush, stall and mid-run reset.
module tb_cdb_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clr_in;
   logic        alu_ready, lsb_ready;
   logic [3:0]  alu_rob_index, lsb_rob_index;
   logic [31:0] alu_result, lsb_result;
   logic        alu_full, lsb_full;
   logic        cdb_valid, cdb_src;
   logic [3:0]  cdb_rob_index;
   logic [31:0] cdb_result;

   int n_checks = 0;
   int n_pass   = 0;
   int n_viol   = 0;
   logic [4:0] exp_q [$];

   cdb_arbiter #(.ROB_IDX_W(4), .DATA_W(32), .FIFO_DEPTH(2)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .clr_in        (clr_in),
      .alu_ready     (alu_ready),
      .alu_rob_index (alu_rob_index),
      .alu_result    (alu_result),
      .alu_full      (alu_full),
      .lsb_ready     (lsb_ready),
      .lsb_rob_index (lsb_rob_index),
      .lsb_result    (lsb_result),
      .lsb_full      (lsb_full),
      .cdb_valid     (cdb_valid),
      .cdb_rob_index (cdb_rob_index),
      .cdb_result    (cdb_result),
      .cdb_src       (cdb_src)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] res_of(input logic src, input logic [3:0] tag);
      return src ? (32'hB0B0_0000 + 32'(tag)) : (32'hA0A0_0000 + 32'(tag));
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic drive(input logic av, input logic [3:0] at, input logic lv, input logic [3:0] lt);
      alu_ready     = av;
      alu_rob_index = at;
      alu_result    = res_of(1'b0, at);
      lsb_ready     = lv;
      lsb_rob_index = lt;
      lsb_result    = res_of(1'b1, lt);
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 1'b0, 4'd0);
   endtask

   // A source offering a result while its queue reports full is a protocol
   // violation; count them so a test can confirm the one it plants.
   task automatic tick();
      if (!rst_in && rdy_in && !clr_in && alu_ready && alu_full) n_viol++;
      if (!rst_in && rdy_in && !clr_in && lsb_ready && lsb_full) n_viol++;
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      rdy_in = 1'b1;
      clr_in = 1'b0;
      idle();
      tick();
      rst_in = 1'b0;
   endtask

   task automatic chk_cdb(input string tg, input logic v, input logic s, input logic [3:0] t);
      check({tg, ".valid"}, 32'(cdb_valid), 32'(v));
      if (v) begin
         check({tg, ".tag"}, 32'(cdb_rob_index), 32'(t));
         check({tg, ".src"}, 32'(cdb_src), 32'(s));
         check({tg, ".res"}, cdb_result, res_of(s, t));
      end
   endtask

   task automatic chk_next(input string tg);
      logic [4:0] e;
      if (exp_q.size() == 0) begin
         check({tg, ".q_empty"}, 32'(1), 32'(0));
      end else begin
         e = exp_q.pop_front();
         chk_cdb(tg, 1'b1, e[4], e[3:0]);
      end
   endtask

   initial begin
      rst_in = 1'b1;
      rdy_in = 1'b1;
      clr_in = 1'b0;
      idle();
      tick();
      tick();
      rst_in = 1'b0;

      // Reset state
      check("rst.valid", 32'(cdb_valid), 32'd0);
      check("rst.tag", 32'(cdb_rob_index), 32'd0);
      check("rst.res", cdb_result, 32'd0);
      check("rst.src", 32'(cdb_src), 32'd0);
      check("rst.alu_full", 32'(alu_full), 32'd0);
      check("rst.lsb_full", 32'(lsb_full), 32'd0);

      // Single ALU result: one-cycle latency, then outputs hold with valid low
      drive(1'b1, 4'd3, 1'b0, 4'd0);
      alu_result = 32'h11;
      tick();
      idle();
      check("single.e0_valid", 32'(cdb_valid), 32'd0);
      tick();
      check("single.valid", 32'(cdb_valid), 32'd1);
      check("single.tag", 32'(cdb_rob_index), 32'd3);
      check("single.res", cdb_result, 32'h11);
      check("single.src", 32'(cdb_src), 32'd0);
      tick();
      check("single.e2_valid", 32'(cdb_valid), 32'd0);
      check("single.e2_tag_hold", 32'(cdb_rob_index), 32'd3);
      check("single.e2_res_hold", cdb_result, 32'h11);

      // Contention: ALU wins the first tie after reset
      do_reset();
      drive(1'b1, 4'd1, 1'b1, 4'd2);
      tick();
      idle();
      chk_cdb("tie.e0", 1'b0, 1'b0, 4'd0);
      tick();
      chk_cdb("tie.e1", 1'b1, 1'b0, 4'd1);
      tick();
      chk_cdb("tie.e2", 1'b1, 1'b1, 4'd2);
      tick();
      chk_cdb("tie.e3", 1'b0, 1'b0, 4'd0);

      // Fill and full, with one push offered while ALU is full
      do_reset();
      n_viol = 0;
      exp_q = {5'h04, 5'h17, 5'h05, 5'h18, 5'h06, 5'h19};
      drive(1'b1, 4'd4, 1'b1, 4'd7);
      tick();
      chk_cdb("fill.e0", 1'b0, 1'b0, 4'd0);
      drive(1'b1, 4'd5, 1'b1, 4'd8);
      tick();
      chk_next("fill.e1");
      check("fill.e1_lsb_full", 32'(lsb_full), 32'd1);
      check("fill.e1_alu_full", 32'(alu_full), 32'd0);
      drive(1'b1, 4'd6, 1'b0, 4'd0);
      tick();
      chk_next("fill.e2");
      check("fill.e2_alu_full", 32'(alu_full), 32'd1);
      check("fill.e2_lsb_full", 32'(lsb_full), 32'd0);
      drive(1'b1, 4'd10, 1'b1, 4'd9);
      tick();
      idle();
      chk_next("fill.e3");
      check("fill.e3_alu_full", 32'(alu_full), 32'd0);
      check("fill.e3_lsb_full", 32'(lsb_full), 32'd1);
      check("fill.violations", 32'(n_viol), 32'd1);
      for (int i = 4; i <= 6; i++) begin
         tick();
         chk_next($sformatf("fill.e%0d", i));
      end
      tick();
      chk_cdb("fill.e7", 1'b0, 1'b0, 4'd0);

      // Flush with a same-cycle push; fairness history survives the flush
      do_reset();
      drive(1'b1, 4'd1, 1'b1, 4'd3);
      tick();
      drive(1'b1, 4'd2, 1'b1, 4'd4);
      tick();
      chk_cdb("flush.e1", 1'b1, 1'b0, 4'd1);
      drive(1'b1, 4'd5, 1'b0, 4'd0);
      tick();
      idle();
      chk_cdb("flush.e2", 1'b1, 1'b1, 4'd3);
      check("flush.e2_alu_full", 32'(alu_full), 32'd1);
      tick();
      chk_cdb("flush.e3", 1'b1, 1'b0, 4'd2);
      drive(1'b1, 4'd9, 1'b0, 4'd0);
      clr_in = 1'b1;
      tick();
      clr_in = 1'b0;
      idle();
      check("flush.valid", 32'(cdb_valid), 32'd0);
      check("flush.alu_full", 32'(alu_full), 32'd0);
      check("flush.lsb_full", 32'(lsb_full), 32'd0);
      drive(1'b1, 4'd11, 1'b1, 4'd12);
      tick();
      idle();
      chk_cdb("flush.e5", 1'b0, 1'b0, 4'd0);
      tick();
      chk_cdb("flush.e6", 1'b1, 1'b1, 4'd12);
      tick();
      chk_cdb("flush.e7", 1'b1, 1'b0, 4'd11);
      tick();
      chk_cdb("flush.e8", 1'b0, 1'b0, 4'd0);

      // Stall: rdy_in low freezes everything, including a pending pop
      do_reset();
      drive(1'b1, 4'd5, 1'b0, 4'd0);
      tick();
      drive(1'b1, 4'd6, 1'b0, 4'd0);
      tick();
      chk_cdb("stall.e1", 1'b1, 1'b0, 4'd5);
      rdy_in = 1'b0;
      drive(1'b0, 4'd0, 1'b1, 4'd7);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_cdb($sformatf("stall.hold%0d", i), 1'b1, 1'b0, 4'd5);
      end
      rdy_in = 1'b1;
      idle();
      tick();
      chk_cdb("stall.resume", 1'b1, 1'b0, 4'd6);
      tick();
      chk_cdb("stall.after", 1'b0, 1'b0, 4'd0);

      // Reset mid-operation discards everything queued
      do_reset();
      drive(1'b1, 4'd1, 1'b1, 4'd2);
      tick();
      drive(1'b1, 4'd3, 1'b1, 4'd4);
      tick();
      drive(1'b1, 4'd5, 1'b0, 4'd0);
      tick();
      check("mrst.pre_alu_full", 32'(alu_full), 32'd1);
      rst_in = 1'b1;
      drive(1'b1, 4'd7, 1'b1, 4'd7);
      tick();
      rst_in = 1'b0;
      idle();
      check("mrst.valid", 32'(cdb_valid), 32'd0);
      check("mrst.tag", 32'(cdb_rob_index), 32'd0);
      check("mrst.res", cdb_result, 32'd0);
      check("mrst.src", 32'(cdb_src), 32'd0);
      check("mrst.alu_full", 32'(alu_full), 32'd0);
      check("mrst.lsb_full", 32'(lsb_full), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("mrst.quiet%0d", i), 32'(cdb_valid), 32'd0);
      end
      drive(1'b1, 4'd8, 1'b1, 4'd9);
      tick();
      idle();
      chk_cdb("mrst.e0", 1'b0, 1'b0, 4'd0);
      tick();
      chk_cdb("mrst.e1", 1'b1, 1'b0, 4'd8);
      tick();
      chk_cdb("mrst.e2", 1'b1, 1'b1, 4'd9);
      tick();
      chk_cdb("mrst.e3", 1'b0, 1'b0, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter ROB_IDX_W, default 4, SHALL set the ROB index width.
REQ-002 Parameter DATA_W, default 32, SHALL set the result width.
REQ-003 Parameter FIFO_DEPTH, default 2, SHALL set entries per source queue; legal values are powers of two, 2 or more.
REQ-004 Port list, one per line (name, direction, width, meaning); clock and reset ports:
- clk_in  in  1  sole clock; all state updates on its rising edge.
- rst_in  in  1  reset; synchronous, active-high.
- rdy_in  in  1  global enable; low freezes all state.
- clr_in  in  1  synchronous pipeline flush (mispredict).
REQ-005 ALU-side ports:
- alu_ready  in  1  ALU result valid this cycle.
- alu_rob_index  in  ROB_IDX_W  ROB tag of the ALU result.
- alu_result  in  DATA_W  ALU result value.
- alu_full  out  1  ALU queue holds FIFO_DEPTH entries.
REQ-006 LSB-side ports:
- lsb_ready  in  1  LSB result valid this cycle.
- lsb_rob_index  in  ROB_IDX_W  ROB tag of the LSB result.
- lsb_result  in  DATA_W  LSB result value.
- lsb_full  out  1  LSB queue holds FIFO_DEPTH entries.
REQ-007 Broadcast ports:
- cdb_valid  out  1  broadcast valid.
- cdb_rob_index  out  ROB_IDX_W  tag being broadcast.
- cdb_result  out  DATA_W  value being broadcast.
- cdb_src  out  1  source of the broadcast; 0 = ALU, 1 = LSB.

Function
REQ-008 Each source SHALL have a private FIFO of FIFO_DEPTH entries {rob_index, result}, with read/write pointers that wrap modulo FIFO_DEPTH and an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-009 Push: at a rising edge with rdy_in=1, clr_in=0, src_ready=1 and src_full=0, the entry SHALL be written and the count incremented.
REQ-010 A push attempted while src_full=1 SHALL be discarded with no state change; this is a protocol violation that the bench flags.
REQ-011 src_full SHALL be registered-count based, equal to (count==FIFO_DEPTH); it SHALL NOT account for a same-cycle pop.
REQ-012 Grant (combinational, from the current FIFO state):
- Neither FIFO non-empty: no grant.
- Exactly one FIFO non-empty: grant that FIFO.
- Both non-empty: grant the source opposite to last_grant.
REQ-013 On a grant with rdy_in=1 and clr_in=0:
- The head entry is popped.
- cdb_valid, cdb_rob_index, cdb_result and cdb_src are registered from it.
- last_grant is set to the granted source.
REQ-014 With no grant, cdb_valid SHALL be 0 after the edge, and the tag, result and src outputs SHALL hold their values.
REQ-015 Push and pop on the same FIFO in the same cycle SHALL leave the count unchanged; the pushed entry SHALL be ordered behind the popped head.
REQ-016 Latency: a result sampled at edge E into an empty FIFO SHALL appear with cdb_valid=1 after edge E+1 (visible the cycle after E+1); there is no same-cycle bypass.
REQ-017 Throughput: exactly one broadcast per cycle; per-source order SHALL be FIFO; under sustained contention the sources SHALL alternate strictly.
REQ-018 rdy_in=0 (with rst_in=0 and clr_in=0) SHALL freeze the FIFOs, pointers, counts, last_grant and all outputs, including cdb_valid.
REQ-019 clr_in=1 SHALL, at the edge and regardless of rdy_in:
- Empty both FIFOs: pointers and counts to 0.
- Clear cdb_valid.
- Drop any same-cycle push.
- Retain last_grant.
REQ-020 Priority SHALL be rst_in, then clr_in, then rdy_in.

Reset
REQ-021 rst_in=1 at an edge SHALL:
- Set pointers and counts to 0, and alu_full and lsb_full to 0.
- Set cdb_valid to 0, cdb_rob_index to 0, cdb_result to 0, cdb_src to 0.
- Set last_grant to LSB, so ALU wins the first tie.
REQ-022 Reset mid-operation SHALL discard all queued and in-flight results, with no broadcast at the following cycle.

Verification
REQ-023 Single ALU: alu_ready with tag 3, result 0x11 at E0 -> after E1: cdb_valid=1, cdb_rob_index=3, cdb_result=0x11, cdb_src=0; after E2: cdb_valid=0.
REQ-024 Contention: ALU tag 1 and LSB tag 2 both at E0, first tie after reset -> tag 1 (src 0) after E1, tag 2 (src 1) after E2.
REQ-025 Fill and full: ALU pushes tags 4, 5, 6 on E0, E1, E2 while LSB is busy with tags 7, 8, 9 -> alu_full=1 while the count is 2, and the broadcast order alternates ALU and LSB with each source's own tags in order.
REQ-026 Flush: two entries queued in each FIFO, then clr_in with alu_ready tag 9 -> after the edge: both counts 0, cdb_valid=0, and tag 9 is never broadcast.
REQ-027 Stall: an entry queued, rdy_in held 0 for 3 cycles -> no pop and all outputs frozen; rdy_in back to 1 -> broadcast after the next edge.
REQ-028 Reset mid-operation: full FIFOs, rst_in for one edge -> all outputs 0, and no stale tag ever appears afterward.
